// File: rtl/rv_plic_cc_ctrl.sv
// Per-target PLIC claim/complete controller: snapshots the arbiter ID, turns CC reads/writes
// into one-hot claim/complete pulses and tracks in-flight sources. Optional: RV_PLIC_CC_ERRCNT_EN.
module rv_plic_cc_ctrl #(
  parameter int N_SOURCE = 32,
  parameter int SRCW     = 6,
  parameter int HOLDOFF  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cc_re_i,
  input  logic                cc_we_i,
  input  logic [SRCW-1:0]     cc_wdata_i,
  input  logic [SRCW-1:0]     max_id_i,
  output logic [SRCW-1:0]     cc_rdata_o,
  output logic [N_SOURCE-1:0] claim_o,
  output logic [N_SOURCE-1:0] complete_o,
  output logic [N_SOURCE-1:0] inflight_o,
  output logic [7:0]          err_cnt_o
);

  localparam int HW = 3;

  logic [SRCW-1:0]     r_id_q;
  logic [HW-1:0]       r_hold;
  logic [N_SOURCE-1:0] r_claim;
  logic [N_SOURCE-1:0] r_cmp;
  logic [N_SOURCE-1:0] r_infl;

  logic [N_SOURCE-1:0] w_id_hit;
  logic [N_SOURCE-1:0] w_wr_hit;
  logic [N_SOURCE-1:0] w_cmp_vec;
  logic [N_SOURCE-1:0] w_clm_vec;
  logic [N_SOURCE-1:0] w_infl_mid;
  logic                w_cmp_ok;
  logic                w_clm_ok;

  // One-hot decode of the snapshot and write IDs; out-of-range IDs decode to all-zero.
  always_comb begin
    w_id_hit = '0;
    w_wr_hit = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      w_id_hit[i] = (r_id_q == SRCW'(i + 1));
      w_wr_hit[i] = (cc_wdata_i == SRCW'(i + 1));
    end
  end

  assign w_cmp_ok   = cc_we_i & (|(w_wr_hit & r_infl));
  assign w_cmp_vec  = w_cmp_ok ? w_wr_hit : '0;
  // Complete retires first, so a same-ID claim in the same cycle sees the source as free.
  assign w_infl_mid = r_infl & ~w_cmp_vec;
  assign w_clm_ok   = cc_re_i & (|w_id_hit) & ~(|(w_id_hit & w_infl_mid));
  assign w_clm_vec  = w_clm_ok ? w_id_hit : '0;

  // Stage p0 -> p1: pulses, in-flight map, ID snapshot and holdoff.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id_q  <= '0;
      r_hold  <= '0;
      r_claim <= '0;
      r_cmp   <= '0;
      r_infl  <= '0;
    end else begin
      r_claim <= w_clm_vec;
      r_cmp   <= w_cmp_vec;
      r_infl  <= w_infl_mid | w_clm_vec;
      // The claim cycle itself forces the next snapshot to 0, so the counter loads one less.
      if (w_clm_ok) begin
        r_hold <= HW'(HOLDOFF - 1);
      end else if (r_hold != '0) begin
        r_hold <= r_hold - HW'(1);
      end
      r_id_q <= (w_clm_ok || (r_hold != '0)) ? '0 : max_id_i;
    end
  end

  assign cc_rdata_o = r_id_q;
  assign claim_o    = r_claim;
  assign complete_o = r_cmp;
  assign inflight_o = r_infl;

`ifdef RV_PLIC_CC_ERRCNT_EN
  logic       w_err;
  logic [7:0] r_err_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A cycle with both a bad claim and a bad complete still counts once.
  assign w_err = (cc_we_i & ~w_cmp_ok) | (cc_re_i & (r_id_q != '0) & ~w_clm_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
    end else if (w_err) begin
      r_err_cnt <= sat_inc8(r_err_cnt);
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: doc/rv_plic_cc_ctrl.md
Name: rv_plic_cc_ctrl

Overview:
- Per-target claim/complete controller for the PLIC.
- Sits directly downstream of the external (hardware-backed) CC register slice. Consumes its read strobe, write strobe and write data; sources the value the slice returns on read.
- Converts software claim reads and complete writes into one-hot claim/complete pulses toward the interrupt gateways.
- Tracks in-flight (claimed, not completed) sources and blocks double-claims.

Parameters:
- N_SOURCE, 32, number of interrupt sources; valid IDs 1..N_SOURCE, ID 0 = "no interrupt".
- SRCW, 6, ID width; must satisfy 2^SRCW > N_SOURCE.
- HOLDOFF, 2, cycles the returned ID is forced to 0 after a claim (range 1..7).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- cc_re_i  input  1  claim strobe (register read of CC), single-cycle
- cc_we_i  input  1  complete strobe (register write of CC), single-cycle
- cc_wdata_i  input  SRCW  ID written on complete
- max_id_i  input  SRCW  highest-priority pending, enabled, above-threshold ID from the target arbiter; 0 if none
- cc_rdata_o  output  SRCW  ID returned to software on claim read (feeds slice read data)
- claim_o  output  N_SOURCE  one-hot claim pulse to gateways
- complete_o  output  N_SOURCE  one-hot complete pulse to gateways
- inflight_o  output  N_SOURCE  bitmap of claimed-not-completed sources
- err_cnt_o  output  8  ignored-request counter (see Optional Feature)

Behaviour:
- Reset (async, rst_ni=0): cc_rdata_o=0, claim_o=0, complete_o=0, inflight_o=0, err_cnt_o=0, holdoff counter=0. Reset mid-operation discards all in-flight state; no pulses are emitted.
- ID snapshot:
  - Each cycle, id_q <= (holdoff_cnt != 0) ? 0 : max_id_i. If holdoff_cnt != 0, it decrements.
  - cc_rdata_o = id_q (registered). Software read returns the snapshot taken the previous cycle.
- Claim, evaluated in the cycle cc_re_i=1, using current id_q:
  - id_q==0: no effect; read returns 0.
  - id_q in 1..N_SOURCE and inflight[id_q-1]==0: next cycle claim_o[id_q-1]=1 for exactly one cycle; inflight[id_q-1] set; holdoff_cnt <= HOLDOFF, so id_q reads 0 for HOLDOFF cycles from the next cycle.
  - id_q > N_SOURCE, or inflight already set: no pulse, no state change; counts as error.
- Complete, evaluated in the cycle cc_we_i=1, ID w=cc_wdata_i:
  - w in 1..N_SOURCE and inflight[w-1]==1: next cycle complete_o[w-1]=1 for one cycle; inflight[w-1] cleared.
  - w==0, w>N_SOURCE, or not in flight: ignored; counts as error.
- Simultaneous cc_re_i and cc_we_i:
  - Complete is applied first, then claim, in the same cycle.
  - If both target the same ID: both pulses fire next cycle; inflight ends set.
- At most one claim bit and one complete bit are high per cycle.
- inflight_o is registered, updated together with the pulses.
- Error counting: an error cycle with both claim and complete errors counts as 1.

Optional Feature:
- Macro RV_PLIC_CC_ERRCNT_EN.
- Defined:
  - err_cnt_o is an 8-bit counter incrementing by 1 on each error cycle, saturating at 255.
  - Cleared only by reset.
- Undefined: err_cnt_o tied to 0; no counter flops.

Test Plan:
- Claim: max_id_i=5, pulse cc_re_i -> cc_rdata_o=5 during read; next cycle claim_o=1<<4, inflight_o=0x10; cc_rdata_o=0 for 2 cycles, then follows max_id_i.
- Complete: after the claim above, cc_we_i with wdata=5 -> next cycle complete_o=1<<4 for one cycle, inflight_o=0.
- Bad complete: cc_we_i with wdata=0, then wdata=7 (not in flight), then wdata=40 -> no complete_o, inflight_o unchanged; err_cnt_o=3 (macro on) / 0 (macro off).
- Double claim: max_id_i=3 while source 3 in flight and no holdoff, cc_re_i -> no claim_o, err_cnt_o +1.
- Simultaneous same ID: source 9 in flight, id_q=9, cc_re_i=cc_we_i=1, wdata=9 -> next cycle claim_o and complete_o both =1<<8; inflight_o bit 8 remains 1.
- Reset mid-op: claim source 2, then assert rst_ni=0 during holdoff -> all outputs 0 immediately; after release, cc_rdata_o follows max_id_i after 1 cycle.
